// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   asm_state_t     : word assembler FSM state
//   BYTE_W, OPER_W  : byte width and adder operand width
//   timeout_cycles  : inter-byte timeout (10 bit-times x 5) for a baud select code
package uart_pkg;

  typedef enum logic {IDLE, COLLECT} asm_state_t;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OPER_W = 32;

  // sys_clk cycles per bit at 50 MHz for each baud select code.
  function automatic int unsigned timeout_cycles(input logic [1:0] baud_sel);
    int unsigned bit_cycles;
    case (baud_sel)
      2'd0:    bit_cycles = 5208;  // 9600
      2'd1:    bit_cycles = 2604;  // 19200
      2'd2:    bit_cycles = 868;   // 57600
      default: bit_cycles = 434;   // 115200
    endcase
    return bit_cycles * 10 * 5;
  endfunction

endpackage

// File: rtl/uart_timeout_ctr.sv
// Idle-cycle counter with an expiry pulse.
//   i_clk      : clock, rising edge
//   i_rst_n    : synchronous active-low reset
//   i_clear    : restart the count at zero (wins over i_en)
//   i_en       : count this cycle
//   o_expired  : combinational pulse on the enabled cycle where the count sits at CYCLES-1
module uart_timeout_ctr #(
  parameter int unsigned CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == CW'(CYCLES - 1));
  assign o_expired  = i_en && !i_clear && w_at_limit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_at_limit) r_count <= '0;
      else            r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs received UART bytes into one NUM_BYTES-wide word, first byte in the MSBs.
//   sys_clk, rst           : clock and synchronous active-low reset
//   byte_in, byte_valid    : byte stream from the RX byte core
//   flush                  : abort any partial word (output register untouched)
//   word_out, word_valid   : held output word, valid/ready handshake
//   word_ready             : consumer accepts word_out
//   byte_cnt, busy         : partial-word progress
//   frame_err              : pulse, partial word dropped by inter-byte timeout
//   overflow               : pulse, completed word dropped because output still held
module uart_rx_word_assembler
  import uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2604000
) (
  input  logic                             sys_clk,
  input  logic                             rst,
  input  logic [BYTE_W-1:0]                byte_in,
  input  logic                             byte_valid,
  input  logic                             flush,
  output logic [BYTE_W*NUM_BYTES-1:0]      word_out,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic [$clog2(NUM_BYTES+1)-1:0]   byte_cnt,
  output logic                             busy,
  output logic                             frame_err,
  output logic                             overflow
);

  localparam int unsigned W     = BYTE_W * NUM_BYTES;
  localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);

  asm_state_t       r_state;
  // Only the low W-8 bits are kept: the oldest byte is always shifted out
  // by the completing byte, so it never needs storage of its own.
  logic [W-9:0]     r_shift;
  logic [CNT_W-1:0] r_byte_cnt;
  logic [W-1:0]     r_word_out;
  logic             r_word_valid;
  logic             r_frame_err;
  logic             r_overflow;

  logic [W-1:0]     w_word;
  logic             w_last;
  logic             w_tmo_clear;
  logic             w_tmo_en;
  logic             w_expired;

  assign w_word = {r_shift, byte_in};
  assign w_last = (r_byte_cnt == CNT_W'(NUM_BYTES - 1));

  // Count only idle COLLECT cycles; any byte or flush restarts the window.
  assign w_tmo_clear = (r_state != COLLECT) || byte_valid || flush;
  assign w_tmo_en    = !w_tmo_clear;

  uart_timeout_ctr #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (sys_clk),
    .i_rst_n   (rst),
    .i_clear   (w_tmo_clear),
    .i_en      (w_tmo_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_byte_cnt   <= '0;
      r_word_out   <= '0;
      r_word_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;

      if (r_word_valid && word_ready) r_word_valid <= 1'b0;

      if (flush) begin
        r_state    <= IDLE;
        r_byte_cnt <= '0;
        r_shift    <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (byte_valid) begin
              r_shift    <= w_word[W-9:0];
              r_byte_cnt <= CNT_W'(1);
              r_state    <= COLLECT;
            end
          end
          COLLECT: begin
            if (byte_valid) begin
              r_shift <= w_word[W-9:0];
              if (w_last) begin
                r_state    <= IDLE;
                r_byte_cnt <= '0;
                // Accepting the held word this same edge frees the output.
                if (!r_word_valid || word_ready) begin
                  r_word_out   <= w_word;
                  r_word_valid <= 1'b1;
                end else begin
                  r_overflow <= 1'b1;
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
              end
            end else if (w_expired) begin
              r_state     <= IDLE;
              r_byte_cnt  <= '0;
              r_shift     <= '0;
              r_frame_err <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign word_out   = r_word_out;
  assign word_valid = r_word_valid;
  assign byte_cnt   = r_byte_cnt;
  assign busy       = (r_state == COLLECT);
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
module tb_uart_rx_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        flush;
  logic [63:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic [3:0]  byte_cnt;
  logic        busy;
  logic        frame_err;
  logic        overflow;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  uart_rx_word_assembler #(
    .NUM_BYTES      (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .sys_clk    (clk),
    .rst        (rst_n),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .flush      (flush),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .byte_cnt   (byte_cnt),
    .busy       (busy),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  typedef struct {
    logic        bv;
    logic [7:0]  b;
    logic        fl;
    logic        rdy;
    logic        rstn;
    logic        e_wv;
    logic [63:0] e_word;
    logic [3:0]  e_cnt;
    logic        e_busy;
    logic        e_fe;
    logic        e_ov;
  } vec_t;

  vec_t vecs[$];

  // Word made of bytes base+1 .. base+8, first byte in the MSBs.
  function automatic logic [63:0] mkword(input logic [7:0] base);
    logic [63:0] w = '0;
    for (int i = 1; i <= 8; i++) w = {w[55:0], base + 8'(i)};
    return w;
  endfunction

  function automatic void add(input logic bv, input logic [7:0] b, input logic fl,
                              input logic rdy, input logic rstn, input logic e_wv,
                              input logic [63:0] e_word, input logic [3:0] e_cnt,
                              input logic e_busy, input logic e_fe, input logic e_ov);
    vec_t v;
    v.bv = bv; v.b = b; v.fl = fl; v.rdy = rdy; v.rstn = rstn;
    v.e_wv = e_wv; v.e_word = e_word; v.e_cnt = e_cnt;
    v.e_busy = e_busy; v.e_fe = e_fe; v.e_ov = e_ov;
    vecs.push_back(v);
  endfunction

  // Eight bytes base+1..base+8; rows 1-7 use rdy, the last uses rdy_last.
  function automatic void add_bytes(input logic [7:0] base, input logic rdy,
                                    input logic rdy_last, input logic wv_before,
                                    input logic [63:0] word_before, input logic wv_after,
                                    input logic [63:0] word_after, input logic ov_last);
    for (int i = 1; i <= 7; i++)
      add(1'b1, base + 8'(i), 1'b0, rdy, 1'b1, wv_before, word_before, 4'(i), 1'b1, 1'b0, 1'b0);
    add(1'b1, base + 8'd8, 1'b0, rdy_last, 1'b1, wv_after, word_after, 4'd0, 1'b0, 1'b0, ov_last);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic bv, input logic [7:0] b, input logic fl,
                      input logic rdy, input logic rstn);
    byte_valid = bv; byte_in = b; flush = fl; word_ready = rdy; rst_n = rstn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_wv, input logic [63:0] e_word,
                         input logic [3:0] e_cnt, input logic e_busy, input logic e_fe,
                         input logic e_ov);
    chk({tag, ".word_valid"}, 64'(word_valid), 64'(e_wv));
    chk({tag, ".word_out"},   word_out,        e_word);
    chk({tag, ".byte_cnt"},   64'(byte_cnt),   64'(e_cnt));
    chk({tag, ".busy"},       64'(busy),       64'(e_busy));
    chk({tag, ".frame_err"},  64'(frame_err),  64'(e_fe));
    chk({tag, ".overflow"},   64'(overflow),   64'(e_ov));
  endtask

  initial begin
    logic [63:0] w00, w10, w30, w40;
    w00 = mkword(8'h00);
    w10 = mkword(8'h10);
    w30 = mkword(8'h30);
    w40 = mkword(8'h40);

    // Reset, then 01..08 straight through with the consumer ready.
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0);
    add_bytes(8'h00, 1'b1, 1'b1, 1'b0, '0, 1'b1, w00, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, w00, 4'd0, 1'b0, 1'b0, 1'b0);
    // A held, B dropped with overflow, then A accepted.
    add_bytes(8'h10, 1'b0, 1'b0, 1'b0, w00, 1'b1, w10, 1'b0);
    add_bytes(8'h20, 1'b0, 1'b0, 1'b1, w10, 1'b1, w10, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, w10, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, w10, 4'd0, 1'b0, 1'b0, 1'b0);
    // Held word accepted on the same edge the next word completes.
    add_bytes(8'h30, 1'b0, 1'b0, 1'b0, w10, 1'b1, w30, 1'b0);
    add_bytes(8'h40, 1'b0, 1'b1, 1'b1, w30, 1'b1, w40, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, w40, 4'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].bv, vecs[i].b, vecs[i].fl, vecs[i].rdy, vecs[i].rstn);
      chk_all($sformatf("vec%0d", i), vecs[i].e_wv, vecs[i].e_word, vecs[i].e_cnt,
              vecs[i].e_busy, vecs[i].e_fe, vecs[i].e_ov);
    end

    // Timeout: 3 bytes then idle; frame_err 16 cycles after the 3rd byte.
    for (int i = 1; i <= 3; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      if (k < 16) begin
        chk($sformatf("tmo.wait%0d.frame_err", k), 64'(frame_err), 64'd0);
        chk($sformatf("tmo.wait%0d.byte_cnt", k), 64'(byte_cnt), 64'd3);
      end else begin
        chk_all("tmo.fire", 1'b0, w40, 4'd0, 1'b0, 1'b1, 1'b0);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("tmo.after.frame_err", 64'(frame_err), 64'd0);

    // Byte on the cycle the counter sits at 15: byte wins, counter restarts.
    step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b1);
    chk("bnd.first.byte_cnt", 64'(byte_cnt), 64'd1);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk($sformatf("bnd.idle%0d.frame_err", k), 64'(frame_err), 64'd0);
    end
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b1);
    chk_all("bnd.save", 1'b0, w40, 4'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk($sformatf("bnd.restart%0d.frame_err", k), 64'(frame_err), (k == 16) ? 64'd1 : 64'd0);
    end
    chk("bnd.end.busy", 64'(busy), 64'd0);

    // Flush with a 6th byte: byte ignored, no frame_err, fresh word clean.
    for (int i = 1; i <= 5; i++) step(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b1);
    chk("fl.pre.byte_cnt", 64'(byte_cnt), 64'd5);
    step(1'b1, 8'h56, 1'b1, 1'b0, 1'b1);
    chk_all("fl.flush", 1'b0, w40, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b1);
    chk_all("fl.word", 1'b1, mkword(8'h60), 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    chk("fl.accept.word_valid", 64'(word_valid), 64'd0);

    // Reset mid-word, then reset while a word is held.
    for (int i = 1; i <= 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_all("rst.midword", 1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b1);
      if (i < 8) chk($sformatf("rst.w1.b%0d.byte_cnt", i), 64'(byte_cnt), 64'(i));
    end
    chk_all("rst.w1.word", 1'b1, mkword(8'h80), 4'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_all("rst.held", 1'b0, '0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, 8'h90 + 8'(i), 1'b0, 1'b1, 1'b1);
    chk_all("rst.w2.word", 1'b1, mkword(8'h90), 4'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
